calendar_date_counter: RTL and testbench

- Sequential day/month/year register that advances one day per `day_tick`. `day_tick` comes from the time-of-day counter's midnight carry.
- Handles Gregorian leap years (div-4, not div-100 unless div-400) and month lengths.
- Supports a validated multi-cycle date load.
- Generalises the combinational days-per-month lookup to a parametrised year range, with no hardware divider.

---
 rtl/calendar_date_counter.sv | 191 +++++++++++++++++++
 tb/tb_calendar_date_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar register that advances one day per day_tick.
// Leap years follow the Gregorian rule and are tracked through mod-4/100/400
// residue registers, so no divider is needed. Loads are validated by a small
// FSM that reduces the loaded year to its residues by repeated subtraction.
module calendar_date_counter #(
    parameter int YEAR_W   = 14,
    parameter int MIN_YEAR = 1,
    parameter int MAX_YEAR = 9999,
    parameter int RST_YEAR = 2000,
    parameter int RST_MON  = 1,
    parameter int RST_DAY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [3:0]        ld_mon,
    input  logic [4:0]        ld_day,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        mon,
    output logic [4:0]        day,
    output logic              leap,
    output logic [4:0]        dim,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic              year_wrap,
    output logic              tick_lost
);

    // Year bounds widened by one bit so MAX_YEAR+1 never overflows a compare.
    localparam logic [YEAR_W:0]   MIN_Y    = (YEAR_W+1)'(MIN_YEAR);
    localparam logic [YEAR_W:0]   MAX_Y    = (YEAR_W+1)'(MAX_YEAR);
    localparam logic [YEAR_W-1:0] C400     = YEAR_W'(400);
    localparam logic [YEAR_W-1:0] C100     = YEAR_W'(100);

    // Residues of the reset year and the wrap year, fixed at elaboration.
    localparam logic [1:0] RST_R4   = 2'(RST_YEAR % 4);
    localparam logic [6:0] RST_R100 = 7'(RST_YEAR % 100);
    localparam logic [8:0] RST_R400 = 9'(RST_YEAR % 400);
    localparam logic [1:0] MIN_R4   = 2'(MIN_YEAR % 4);
    localparam logic [6:0] MIN_R100 = 7'(MIN_YEAR % 100);
    localparam logic [8:0] MIN_R400 = 9'(MIN_YEAR % 400);

    typedef enum logic [1:0] {IDLE, R400, R100, CHECK} state_t;

    state_t state, state_nx;

    logic [1:0]        r4;
    logic [6:0]        r100;
    logic [8:0]        r400;

    // Shadow copy of the date being loaded plus its working remainder.
    logic [YEAR_W-1:0] sh_year;
    logic [3:0]        sh_mon;
    logic [4:0]        sh_day;
    logic [YEAR_W-1:0] w;
    logic [8:0]        p400;
    logic [6:0]        p100;

    logic              p_leap;
    logic [4:0]        p_dim;
    logic              ld_valid;

    function automatic logic is_leap(input logic [1:0] m4, input logic [6:0] m100,
                                     input logic [8:0] m400);
        return ((m4 == 2'd0) && (m100 != 7'd0)) || (m400 == 9'd0);
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign leap = is_leap(r4, r100, r400);
    assign dim  = days_in(mon, leap);
    assign busy = (state != IDLE);

    // Calendar checks of the shadow date against the primed residues.
    assign p_leap   = is_leap(sh_year[1:0], p100, p400);
    assign p_dim    = days_in(sh_mon, p_leap);
    assign ld_valid = ({1'b0, sh_year} >= MIN_Y) && ({1'b0, sh_year} <= MAX_Y) &&
                      (sh_mon >= 4'd1) && (sh_mon <= 4'd12) &&
                      (sh_day >= 5'd1) && (sh_day <= p_dim);

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Load FSM next state: reduce by 400s, then by 100s, then validate.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = R400;
            R400:    if (w < C400) state_nx = R100;
            R100:    if (w < C100) state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Date, residues, load datapath and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year      <= YEAR_W'(RST_YEAR);
            mon       <= 4'(RST_MON);
            day       <= 5'(RST_DAY);
            r4        <= RST_R4;
            r100      <= RST_R100;
            r400      <= RST_R400;
            sh_year   <= '0;
            sh_mon    <= '0;
            sh_day    <= '0;
            w         <= '0;
            p400      <= '0;
            p100      <= '0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
            tick_lost <= 1'b0;
        end else begin
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
            // A tick is lost if a load is running or starting this cycle.
            tick_lost <= day_tick && ((state != IDLE) || load);
            case (state)
                IDLE: begin
                    if (load) begin
                        sh_year <= ld_year;
                        sh_mon  <= ld_mon;
                        sh_day  <= ld_day;
                        w       <= ld_year;
                    end else if (day_tick) begin
                        if (day < dim) begin
                            day <= day + 5'd1;
                        end else begin
                            day <= 5'd1;
                            if (mon < 4'd12) begin
                                mon <= mon + 4'd1;
                            end else begin
                                mon <= 4'd1;
                                if ({1'b0, year} < MAX_Y) begin
                                    year <= year + YEAR_W'(1);
                                    r4   <= r4 + 2'd1;
                                    r100 <= (r100 == 7'd99)  ? 7'd0 : r100 + 7'd1;
                                    r400 <= (r400 == 9'd399) ? 9'd0 : r400 + 9'd1;
                                end else begin
                                    year      <= YEAR_W'(MIN_YEAR);
                                    r4        <= MIN_R4;
                                    r100      <= MIN_R100;
                                    r400      <= MIN_R400;
                                    year_wrap <= 1'b1;
                                end
                            end
                        end
                    end
                end
                R400: begin
                    if (w >= C400) w <= w - C400;
                    else           p400 <= w[8:0];
                end
                R100: begin
                    if (w >= C100) w <= w - C100;
                    else           p100 <= w[6:0];
                end
                CHECK: begin
                    if (ld_valid) begin
                        year    <= sh_year;
                        mon     <= sh_mon;
                        day     <= sh_day;
                        r4      <= sh_year[1:0];
                        r100    <= p100;
                        r400    <= p400;
                        load_ok <= 1'b1;
                    end else begin
                        load_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Randomised bench for calendar_date_counter against a plain-arithmetic
// calendar model (year/month/day integers, leap from the % rule).
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        day_tick = 1'b0;
    logic        load = 1'b0;
    logic [13:0] ld_year = '0;
    logic [3:0]  ld_mon = '0;
    logic [4:0]  ld_day = '0;
    logic [13:0] year;
    logic [3:0]  mon;
    logic [4:0]  day;
    logic        leap, busy, load_ok, load_err, year_wrap, tick_lost;
    logic [4:0]  dim;

    int n_tests = 0;
    int n_fail  = 0;
    int my, mm, md;

    calendar_date_counter dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .ld_year(ld_year), .ld_mon(ld_mon), .ld_day(ld_day),
        .year(year), .mon(mon), .day(day), .leap(leap), .dim(dim),
        .busy(busy), .load_ok(load_ok), .load_err(load_err),
        .year_wrap(year_wrap), .tick_lost(tick_lost)
    );

    always #5 clk = ~clk;

    function automatic int m_leap(input int y);
        return (((y % 4) == 0) && ((y % 100) != 0)) || ((y % 400) == 0) ? 1 : 0;
    endfunction

    function automatic int m_dim(input int y, input int m);
        case (m)
            2:          return 28 + m_leap(y);
            4, 6, 9, 11: return 30;
            default:    return 31;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int exp_busy);
        chk({tag, ".year"}, 32'(year), my);
        chk({tag, ".mon"},  32'(mon),  mm);
        chk({tag, ".day"},  32'(day),  md);
        chk({tag, ".leap"}, 32'(leap), m_leap(my));
        chk({tag, ".dim"},  32'(dim),  m_dim(my, mm));
        chk({tag, ".busy"}, 32'(busy), exp_busy);
    endtask

    // One day_tick in IDLE; starts and ends on a falling edge.
    task automatic do_tick();
        int wrap;
        wrap = 0;
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
        if (md < m_dim(my, mm)) md++;
        else begin
            md = 1;
            if (mm < 12) mm++;
            else begin
                mm = 1;
                if (my < 9999) my++;
                else begin my = 1; wrap = 1; end
            end
        end
        chk_date("tick", 0);
        chk("tick.wrap", 32'(year_wrap), wrap);
        chk("tick.lost", 32'(tick_lost), 0);
    endtask

    // Load a date; tick_at>=0 injects a day_tick that many cycles after the
    // load-sampling edge (0 = same cycle as load).
    task automatic do_load(input int y, input int m, input int d, input int tick_at);
        int  lat, k;
        bit  ok, seen;
        ok  = (y >= 1) && (y <= 9999) && (m >= 1) && (m <= 12) &&
              (d >= 1) && (d <= m_dim(y, m));
        lat = 3 + y / 400 + (y % 400) / 100;
        load = 1'b1; ld_year = 14'(y); ld_mon = 4'(m); ld_day = 5'(d);
        day_tick = (tick_at == 0);
        @(negedge clk);
        load = 1'b0; day_tick = 1'b0;
        ld_year = 14'($urandom); ld_mon = 4'($urandom); ld_day = 5'($urandom);
        if (tick_at == 0) chk("load.collide_lost", 32'(tick_lost), 1);
        chk_date("load.start", 1);
        seen = 0; k = 0;
        while (!seen && k < 60) begin
            day_tick = (tick_at > 0) && (k == tick_at);
            load = (k == 2);
            @(negedge clk);
            k++;
            day_tick = 1'b0; load = 1'b0;
            if (tick_at > 0 && k == tick_at + 1) chk("load.tick_lost", 32'(tick_lost), 1);
            if (load_ok || load_err) seen = 1;
            else if (k == 4) chk_date("load.hold", 1);
        end
        chk("load.latency", k, lat);
        chk("load.ok", 32'(load_ok), ok);
        chk("load.err", 32'(load_err), !ok);
        if (ok) begin my = y; mm = m; md = d; end
        chk_date("load.after", 0);
    endtask

    initial begin
        int y, m, d, guard, pulses;
        int yl[11] = '{1900, 2000, 2100, 2400, 2023, 2024, 9999, 1, 4, 100, 400};

        // Reset state, both during and after reset.
        repeat (2) @(negedge clk);
        my = 2000; mm = 1; md = 1;
        chk_date("reset.held", 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_date("reset", 0);
        chk("reset.pulses", 32'({load_ok, load_err, year_wrap, tick_lost}), 0);

        // February boundaries.
        do_load(2000, 2, 28, -1);
        do_tick();
        do_tick();
        do_load(1900, 2, 28, -1);
        do_tick();
        do_load(2024, 2, 29, -1);

        // Invalid loads leave the date alone.
        do_load(2023, 2, 29, -1);
        do_load(2024, 4, 31, -1);
        do_load(2024, 13, 1, -1);
        do_load(0, 1, 1, -1);

        // Worst-case latency with a colliding tick, then wrap.
        do_load(9999, 12, 31, 5);
        do_tick();
        guard = 0;
        while (my != 4 && guard < 1500) begin do_tick(); guard++; end
        chk("wrap.reach_year4", my, 4);
        chk("wrap.leap4", 32'(leap), 1);

        // Reset in the middle of a load.
        load = 1'b1; ld_year = 14'd2400; ld_mon = 4'd1; ld_day = 5'd1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        my = 2000; mm = 1; md = 1;
        chk_date("midrst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (load_ok || load_err) pulses++;
        end
        chk("midrst.no_pulse", pulses, 0);
        chk_date("midrst.after", 0);

        // Randomised mix of ticks and loads.
        repeat (150) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 5)) do_tick();
                1: begin
                    y = $urandom_range(0, 16383);
                    if ($urandom_range(0, 1) == 1) y = $urandom_range(1, 9999);
                    do_load(y, $urandom_range(0, 13), $urandom_range(0, 31), -1);
                end
                2: begin
                    y = ($urandom_range(0, 1) == 1) ? yl[$urandom_range(0, 10)]
                                                    : $urandom_range(1, 9999);
                    m = $urandom_range(1, 12);
                    d = m_dim(y, m);
                    do_load(y, m, d, -1);
                    do_tick();
                end
                default: begin
                    y = $urandom_range(1, 9999);
                    m = $urandom_range(1, 12);
                    d = $urandom_range(1, 28);
                    do_load(y, m, d, $urandom_range(0, 2));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
